cmd_parse: RTL

- Command-frame parser sitting directly downstream of the com receive path and upstream of console.
- Consumes the received byte stream, locates frame headers, checks type, length and an XOR checksum, and publishes the decoded command word (cache_cmd) and block type (read_btype).
- Uses the codebase's fs/fd start/done handshake.
- A frame that fails any check is dropped without disturbing the previously published command.

---
 rtl/cmd_parse.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cmd_parse.sv
// Command-frame parser: hunts for a HEAD0/HEAD1 header in the received byte
// stream, checks type, length and XOR checksum, and publishes the payload
// (cache_cmd) and block type (read_btype) of each good frame. Bad frames
// only bump a saturating error counter. Frames are requested with the fs
// level and acknowledged with the fd level.
//
// The checksum byte must equal the XOR of TYPE, LEN and every payload byte.
// The header bytes are not included in the checksum.
module cmd_parse #(
    parameter logic [7:0] HEAD0   = 8'h55,
    parameter logic [7:0] HEAD1   = 8'hAA,
    parameter int         MAX_LEN = 4,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fs,
    output logic        fd,
    input  logic [7:0]  rxd,
    input  logic        rxen,
    output logic [3:0]  read_btype,
    output logic [31:0] cache_cmd,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
    localparam logic [7:0]    LMAX = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC0 = 3'd1,
        SYNC1 = 3'd2,
        TYPE  = 3'd3,
        LEN   = 3'd4,
        DATA  = 3'd5,
        CHK   = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t        state, state_n;
    logic [31:0]   shadow;
    logic [3:0]    sh_btype;
    logic [7:0]    chk;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;

    logic commit, reject, ld_type, ld_len, shift, timer_inc, clr_fd;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic and datapath control strobes
    always_comb begin
        state_n   = state;
        commit    = 1'b0;
        reject    = 1'b0;
        ld_type   = 1'b0;
        ld_len    = 1'b0;
        shift     = 1'b0;
        timer_inc = 1'b0;
        clr_fd    = 1'b0;
        case (state)
            IDLE: begin
                if (fs) state_n = SYNC0;
            end
            DONE: begin
                if (!fs) begin
                    state_n = IDLE;
                    clr_fd  = 1'b1;
                end
            end
            default: begin
                // Losing fs mid-frame abandons the frame silently.
                if (!fs) begin
                    state_n = IDLE;
                end else if (rxen) begin
                    case (state)
                        SYNC0: begin
                            if (rxd == HEAD0) state_n = SYNC1;
                        end
                        SYNC1: begin
                            if (rxd == HEAD1)      state_n = TYPE;
                            else if (rxd == HEAD0) state_n = SYNC1;
                            else                   state_n = SYNC0;
                        end
                        TYPE: begin
                            if (rxd[7:4] != 4'h0) begin
                                reject = 1'b1;
                            end else begin
                                ld_type = 1'b1;
                                state_n = LEN;
                            end
                        end
                        LEN: begin
                            if (rxd > LMAX) begin
                                reject = 1'b1;
                            end else begin
                                ld_len  = 1'b1;
                                state_n = (rxd != 8'h00) ? DATA : CHK;
                            end
                        end
                        DATA: begin
                            shift = 1'b1;
                            if (cnt == CW'(1)) state_n = CHK;
                        end
                        CHK: begin
                            if (rxd == chk) begin
                                commit  = 1'b1;
                                state_n = DONE;
                            end else begin
                                reject = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (state != SYNC0) begin
                    // Inter-byte gap only matters once HEAD0 has been seen.
                    if (timer == TLIM) reject    = 1'b1;
                    else               timer_inc = 1'b1;
                end
                if (reject) state_n = SYNC0;
            end
        endcase
    end

    // Frame datapath: shadow payload, type, running checksum, byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= 32'h0;
            sh_btype <= 4'h0;
            chk      <= 8'h0;
            cnt      <= '0;
        end else begin
            if (ld_type) begin
                sh_btype <= rxd[3:0];
                chk      <= rxd;
            end
            if (ld_len) begin
                shadow <= 32'h0;
                cnt    <= CW'(rxd);
                chk    <= chk ^ rxd;
            end
            if (shift) begin
                shadow <= {shadow[23:0], rxd};
                cnt    <= cnt - CW'(1);
                chk    <= chk ^ rxd;
            end
        end
    end

    // Inter-byte timer: counts idle cycles, zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         timer <= '0;
        else if (timer_inc) timer <= timer + TW'(1);
        else                timer <= '0;
    end

    // Published outputs: atomic update on a good frame, done flag, error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_cmd  <= 32'h0;
            read_btype <= 4'h0;
            fd         <= 1'b0;
            err_cnt    <= 8'h0;
        end else begin
            if (commit) begin
                cache_cmd  <= shadow;
                read_btype <= sh_btype;
                fd         <= 1'b1;
            end else if (clr_fd) begin
                fd <= 1'b0;
            end
            if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h1;
        end
    end

    assign busy = (state != IDLE) && (state != DONE);

endmodule
